// File: rtl/wb_trace_collector.sv
// Register write-back trace collector: FIFO-buffers write-back events and
// streams each one out as a 5-byte record on a byte-wide valid/ready link.
module wb_trace_collector #(
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reg_write_sig,
    input  logic [RF_ADDRESS-1:0] reg_num,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  trace_en,
    input  logic                  clear_drop,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [AW:0]           fifo_level,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  overflow
);
    localparam int ENT_W = RF_ADDRESS + DATA_W;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_level;
    logic [CNT_W-1:0]  r_drop;
    logic              r_ovf;
    state_t            r_state;
    logic [2:0]        r_idx;
    logic [DATA_W-1:0] r_data;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;

    logic [ENT_W-1:0]  w_head;
    logic              w_empty, w_full, w_last, w_pop, w_cap, w_push, w_drop;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_last  = (r_state == S_SEND) && tx_ready && (r_idx == 3'd4);
    // Pop only from registered state, so a fresh push is never bypassed.
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || w_last);
    assign w_cap   = reg_write_sig && trace_en && (reg_num != '0);
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_drop  = w_cap && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {reg_num, reg_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop on the clearing edge leaves exactly one drop recorded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= '0;
            r_ovf  <= 1'b0;
        end else if (clear_drop) begin
            r_drop <= w_drop ? CNT_W'(1) : '0;
            r_ovf  <= w_drop;
        end else if (w_drop) begin
            if (r_drop != '1)
                r_drop <= r_drop + CNT_W'(1);
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_data     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_pop) begin
            r_state    <= S_SEND;
            r_idx      <= '0;
            r_data     <= w_head[DATA_W-1:0];
            r_tx_data  <= {3'b101, w_head[ENT_W-1 -: RF_ADDRESS]};
            r_tx_valid <= 1'b1;
        end else if (r_state == S_SEND && tx_ready) begin
            if (r_idx == 3'd4) begin
                r_state    <= S_IDLE;
                r_tx_data  <= '0;
                r_tx_valid <= 1'b0;
            end else begin
                r_idx     <= r_idx + 3'd1;
                r_tx_data <= r_data[{r_idx[1:0], 3'b000} +: 8];
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_wb_trace_collector.sv
// Self-checking bench for wb_trace_collector: directed scenarios plus a
// queue-based reference model compared every cycle under random traffic.
module tb_wb_trace_collector;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        reg_write_sig = 1'b0;
    logic [4:0]  reg_num = '0;
    logic [31:0] reg_data = '0;
    logic        trace_en = 1'b1;
    logic        clear_drop = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [3:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    wb_trace_collector #(.DATA_W(32), .RF_ADDRESS(5), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
        .reg_data(reg_data), .trace_en(trace_en), .clear_drop(clear_drop),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Bytes accepted by the sink.
    logic [7:0] rx_q[$];
    always @(posedge clk)
        if (reset_n && tx_valid && tx_ready) rx_q.push_back(tx_data);

    function automatic logic [7:0] rec_byte(input logic [36:0] ev, input int k);
        if (k == 0) return {3'b101, ev[36:32]};
        return ev[8*(k-1) +: 8];
    endfunction

    // Reference model: queue of pending events plus the record being sent.
    logic [36:0] m_q[$];
    logic [36:0] m_cur = '0;
    bit          m_busy = 0;
    int          m_idx = 0;
    logic [7:0]  m_drop = '0;
    bit          m_ovf = 0;
    bit          m_cap;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete(); m_busy = 0; m_idx = 0; m_drop = '0; m_ovf = 0;
        end else begin
            m_cap = reg_write_sig && trace_en && (reg_num != 0);
            if (m_busy && tx_ready) begin
                m_idx++;
                if (m_idx == 5) m_busy = 0;
            end
            if (!m_busy && m_q.size() > 0) begin
                m_cur = m_q.pop_front(); m_idx = 0; m_busy = 1;
            end
            if (clear_drop) begin m_drop = '0; m_ovf = 0; end
            if (m_cap) begin
                if (m_q.size() < DEPTH) m_q.push_back({reg_num, reg_data});
                else begin
                    if (m_drop != 8'hFF) m_drop++;
                    m_ovf = 1;
                end
            end
        end
    end

    task automatic wait_drain(output bit timed_out);
        int c = 0;
        timed_out = 0;
        while ((fifo_level != 0 || tx_valid) && c < 300) begin
            @(negedge clk); c++;
        end
        if (c >= 300) timed_out = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0h exp 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data got %0h exp 0", tx_data); end
        n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %0h exp 0", overflow); end
    endtask

    task automatic test_single;
        logic [7:0] exp_b [5];
        exp_b = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        trace_en = 1; tx_ready = 1; rx_q.delete();
        reg_write_sig = 1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
        @(negedge clk);
        reg_write_sig = 0;
        n_checks++; if (fifo_level !== 4'd1) begin n_errors++; $display("FAIL single_level1 got %0d exp 1", fifo_level); end
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid got %0h exp 0", tx_valid); end
        @(negedge clk);
        n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL single_level0 got %0d exp 0", fifo_level); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[k]) begin
                n_errors++; $display("FAIL single_byte%0d got v=%0h d=%0h exp v=1 d=%0h", k, tx_valid, tx_data, exp_b[k]);
            end
            @(negedge clk);
        end
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL single_end_valid got %0h exp 0", tx_valid); end
    endtask

    task automatic test_x0_disable;
        rx_q.delete();
        reg_write_sig = 1; reg_num = 5'd0; reg_data = 32'h1234; trace_en = 1;
        @(negedge clk);
        reg_num = 5'd3; reg_data = 32'd7; trace_en = 0;
        @(negedge clk);
        reg_write_sig = 0; trace_en = 1;
        repeat (8) @(negedge clk);
        n_checks++; if (rx_q.size() != 0) begin n_errors++; $display("FAIL x0_bytes got %0d exp 0", rx_q.size()); end
        n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL x0_level got %0d exp 0", fifo_level); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_errors++; $display("FAIL x0_drop got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_overflow;
        bit to;
        tx_ready = 0; rx_q.delete();
        for (int i = 1; i <= 10; i++) begin
            reg_write_sig = 1; reg_num = 5'(i); reg_data = 32'hA000_0000 + 32'(i);
            @(negedge clk);
        end
        reg_write_sig = 0;
        n_checks++; if (drop_cnt !== 8'd1) begin n_errors++; $display("FAIL ovf_drop got %0d exp 1", drop_cnt); end
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %0h exp 1", overflow); end
        n_checks++; if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL ovf_level got %0d exp 8", fifo_level); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin n_errors++; $display("FAIL ovf_stall got v=%0h d=%0h exp v=1 d=a1", tx_valid, tx_data); end
        tx_ready = 1;
        wait_drain(to);
        n_checks++; if (to) begin n_errors++; $display("FAIL ovf_drain timed out level=%0d", fifo_level); end
        n_checks++; if (rx_q.size() != 45) begin n_errors++; $display("FAIL ovf_count got %0d exp 45", rx_q.size()); end
        if (rx_q.size() == 45)
            for (int r = 0; r < 9; r++)
                for (int k = 0; k < 5; k++) begin
                    logic [7:0] e;
                    e = rec_byte({5'(r+1), 32'hA000_0000 + 32'(r+1)}, k);
                    n_checks++;
                    if (rx_q[r*5+k] !== e) begin n_errors++; $display("FAIL ovf_rec%0d_b%0d got %0h exp %0h", r+1, k, rx_q[r*5+k], e); end
                end
        clear_drop = 1; @(negedge clk); clear_drop = 0;
        n_checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got %0d/%0h exp 0/0", drop_cnt, overflow); end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_b[$];
        logic [7:0] prev_d = '0;
        bit prev_v = 0, prev_r = 0;
        int c = 0;
        rx_q.delete();
        while ((c < 3 || rx_q.size() < 15 || tx_valid) && c < 400) begin
            if (prev_v && !prev_r) begin
                n_checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_d) begin n_errors++; $display("FAIL bp_hold got v=%0h d=%0h exp v=1 d=%0h", tx_valid, tx_data, prev_d); end
            end
            n_checks++;
            if (tx_valid !== m_busy || tx_data !== (m_busy ? rec_byte(m_cur, m_idx) : 8'h00) || fifo_level !== 4'(m_q.size())) begin
                n_errors++; $display("FAIL bp_model got v=%0h d=%0h l=%0d exp v=%0h d=%0h l=%0d", tx_valid, tx_data, fifo_level, m_busy, m_busy ? rec_byte(m_cur, m_idx) : 8'h00, m_q.size());
            end
            if (c < 3) begin
                reg_write_sig = 1; reg_num = 5'($urandom_range(1, 31)); reg_data = $urandom;
                for (int k = 0; k < 5; k++) exp_b.push_back(rec_byte({reg_num, reg_data}, k));
            end else reg_write_sig = 0;
            tx_ready = $urandom_range(0, 1);
            prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
            @(negedge clk); c++;
        end
        reg_write_sig = 0;
        n_checks++; if (c >= 400) begin n_errors++; $display("FAIL bp_timeout got %0d bytes exp 15", rx_q.size()); end
        n_checks++; if (rx_q.size() != 15) begin n_errors++; $display("FAIL bp_count got %0d exp 15", rx_q.size()); end
        for (int i = 0; i < 15 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_b[i]) begin n_errors++; $display("FAIL bp_byte%0d got %0h exp %0h", i, rx_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_clear_collision;
        bit to;
        tx_ready = 0;
        for (int i = 0; i < 14; i++) begin
            reg_write_sig = 1; reg_num = 5'((i % 31) + 1); reg_data = $urandom;
            @(negedge clk);
        end
        reg_write_sig = 0;
        n_checks++; if (drop_cnt !== 8'd5) begin n_errors++; $display("FAIL coll_pre got %0d exp 5", drop_cnt); end
        reg_write_sig = 1; reg_num = 5'd9; clear_drop = 1;
        @(negedge clk);
        reg_write_sig = 0; clear_drop = 0;
        n_checks++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin n_errors++; $display("FAIL coll_clear got %0d/%0h exp 1/1", drop_cnt, overflow); end
        clear_drop = 1; @(negedge clk); clear_drop = 0;
        for (int i = 0; i < 300; i++) begin
            reg_write_sig = 1; reg_num = 5'd2; reg_data = 32'(i);
            @(negedge clk);
        end
        reg_write_sig = 0;
        n_checks++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin n_errors++; $display("FAIL sat got %0d/%0h exp 255/1", drop_cnt, overflow); end
        clear_drop = 1; tx_ready = 1; @(negedge clk); clear_drop = 0;
        wait_drain(to);
        n_checks++; if (to) begin n_errors++; $display("FAIL coll_drain timed out level=%0d", fifo_level); end
    endtask

    task automatic test_reset_mid;
        bit to;
        logic [7:0] exp_b [5];
        exp_b = '{8'hA7, 8'h44, 8'h33, 8'h22, 8'h11};
        tx_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            reg_write_sig = 1; reg_num = 5'(i); reg_data = $urandom;
            @(negedge clk);
        end
        reg_write_sig = 0;
        tx_ready = 1; repeat (3) @(negedge clk);
        tx_ready = 0;
        n_checks++; if (fifo_level !== 4'd3) begin n_errors++; $display("FAIL rmid_pre_level got %0d exp 3", fifo_level); end
        #2 reset_n = 0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid got %0h exp 0", tx_valid); end
        n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL rmid_level got %0d exp 0", fifo_level); end
        @(negedge clk);
        reset_n = 1; rx_q.delete(); tx_ready = 1;
        @(negedge clk);
        reg_write_sig = 1; reg_num = 5'd7; reg_data = 32'h11223344;
        @(negedge clk);
        reg_write_sig = 0;
        wait_drain(to);
        n_checks++; if (to || rx_q.size() != 5) begin n_errors++; $display("FAIL rmid_count got %0d exp 5", rx_q.size()); end
        for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
            n_checks++;
            if (rx_q[k] !== exp_b[k]) begin n_errors++; $display("FAIL rmid_byte%0d got %0h exp %0h", k, rx_q[k], exp_b[k]); end
        end
    endtask

    task automatic test_random;
        int bad = 0;
        for (int c = 0; c < 1500; c++) begin
            n_checks++;
            if (tx_valid !== m_busy || tx_data !== (m_busy ? rec_byte(m_cur, m_idx) : 8'h00) ||
                fifo_level !== 4'(m_q.size()) || drop_cnt !== m_drop || overflow !== m_ovf) begin
                n_errors++; bad++;
                if (bad < 10)
                    $display("FAIL rand_c%0d got v=%0h d=%0h l=%0d dc=%0d o=%0h exp v=%0h d=%0h l=%0d dc=%0d o=%0h",
                             c, tx_valid, tx_data, fifo_level, drop_cnt, overflow,
                             m_busy, m_busy ? rec_byte(m_cur, m_idx) : 8'h00, m_q.size(), m_drop, m_ovf);
            end
            reg_write_sig = ($urandom_range(0, 2) != 0);
            reg_num = 5'($urandom_range(0, 31));
            reg_data = $urandom;
            trace_en = ($urandom_range(0, 7) != 0);
            clear_drop = ($urandom_range(0, 60) == 0);
            tx_ready = (c % 300 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        reg_write_sig = 0; clear_drop = 0; trace_en = 1;
    endtask

    initial begin
        #1 reset_n = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_x0_disable();
        test_overflow();
        test_backpressure();
        test_clear_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
